// File: rtl/spart_key_rx.sv
// spart_key_rx: 8N1 serial receiver that turns WASD/space key bytes into a
// one-hot key vector, strobed to the CPU's SPART interface for one cycle.
module spart_key_rx #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       SPART_we,
  output logic [4:0] SPART_keys,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE, WAIT_IDLE} state_t;

  state_t      state, state_nxt;
  logic        rx_m, rx_s;
  logic [15:0] cnt;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        tick;
  logic [4:0]  key_lut;
  logic        key_hit;
  logic        we_nxt, ferr_nxt;
  logic [4:0]  keys_nxt;

  assign tick = (cnt == 16'd0);

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && bitcnt == 3'd7) state_nxt = STOP;
      STOP:      if (tick) state_nxt = rx_s ? DECODE : WAIT_IDLE;
      DECODE:    state_nxt = IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Baud counter, bit counter and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        IDLE: if (!rx_s) cnt <= HALF_M1;
        START:
          if (tick) begin
            cnt    <= BAUD_M1;
            bitcnt <= '0;
          end else cnt <= cnt - 16'd1;
        DATA:
          if (tick) begin
            shreg[bitcnt] <= rx_s;
            bitcnt        <= bitcnt + 3'd1;
            cnt           <= BAUD_M1;
          end else cnt <= cnt - 16'd1;
        STOP: if (!tick) cnt <= cnt - 16'd1;
        default: ;
      endcase
    end
  end

  // Key lookup on the received byte (both cases accepted)
  always_comb begin
    key_lut = 5'b00000;
    key_hit = 1'b1;
    case (shreg)
      8'h77, 8'h57: key_lut = 5'b00001;
      8'h73, 8'h53: key_lut = 5'b00010;
      8'h61, 8'h41: key_lut = 5'b00100;
      8'h64, 8'h44: key_lut = 5'b01000;
      8'h20:        key_lut = 5'b10000;
      default:      key_hit = 1'b0;
    endcase
  end

  // Output decode: next strobe/key/error values and busy flag
  always_comb begin
    we_nxt   = (state == DECODE) && key_hit;
    keys_nxt = we_nxt ? key_lut : SPART_keys;
    ferr_nxt = (state == STOP) && tick && !rx_s;
    rx_busy  = (state != IDLE);
  end

  // Registered outputs; strobe lands on the edge leaving DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SPART_we   <= 1'b0;
      SPART_keys <= 5'h00;
      frame_err  <= 1'b0;
    end else begin
      SPART_we   <= we_nxt;
      SPART_keys <= keys_nxt;
      frame_err  <= ferr_nxt;
    end
  end

endmodule
